// File: rtl/post_neuron_sram_ctrl.sv
// ---------------------------------------------------------------------------
// post_neuron_sram_ctrl
//
// Arbitrating sequencer for the single-port post-neuron state SRAM
// (CS/WE/A/D/Q interface, one-cycle registered read). The SRAM is shared
// between two requesters:
//   - the spike-integration path, which runs a read-modify-write: add a signed
//     delta to the membrane, compare against THRESHOLD, fire, write back;
//   - the host/readout path, which issues plain reads and writes.
// All operations are fully serialized, so a back-to-back read-modify-write
// to the same neuron always sees the previous write-back.
//
// SRAM word layout: {cnt[DATA_WIDTH-1:MEM_W], mem[MEM_W-1:0]}
//   mem : signed two's-complement membrane potential
//   cnt : unsigned spike counter, saturates at all-ones
//
// Build option:
//   PNS_MEM_SAT_EN  defined   -> membrane sum clamps to the signed MEM_W range
//                   undefined -> membrane sum wraps modulo 2^MEM_W
//
// Ports:
//   CLK, RST          clock (rising edge), synchronous active-high reset
//   int_req/int_addr/int_delta   integration request (held until int_ack)
//   int_ack           one-cycle grant pulse (combinational, IDLE cycle)
//   host_req/host_we/host_addr/host_wdata   host request (held until host_ack)
//   host_ack          one-cycle grant pulse (combinational, IDLE cycle)
//   host_rdata/host_rvalid   host read data and its one-cycle strobe
//   spike_valid/spike_addr   one-cycle fire pulse and neuron index
//   sram_cs/sram_we/sram_a/sram_d   SRAM control, address and write data
//   sram_q            SRAM read data, valid the cycle after a CS read
//   busy              high whenever the sequencer is not IDLE
// ---------------------------------------------------------------------------
module post_neuron_sram_ctrl #(
  parameter int                      ADDR_WIDTH = 8,
  parameter int                      DATA_WIDTH = 32,
  parameter int                      MEM_W      = 16,
  parameter logic signed [MEM_W-1:0] THRESHOLD  = 16'sd1024
) (
  input  logic                  CLK,
  input  logic                  RST,
  // integration requester
  input  logic                  int_req,
  input  logic [ADDR_WIDTH-1:0] int_addr,
  input  logic [MEM_W-1:0]      int_delta,
  output logic                  int_ack,
  // host requester
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_ack,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  host_rvalid,
  // spike output
  output logic                  spike_valid,
  output logic [ADDR_WIDTH-1:0] spike_addr,
  // SRAM interface
  output logic                  sram_cs,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q,
  // status
  output logic                  busy
);

  localparam int CNT_W = DATA_WIDTH - MEM_W;

  // rr_last encoding: which requester was granted most recently
  localparam logic RR_INT  = 1'b0;
  localparam logic RR_HOST = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CALC = 3'd2,
    ST_WB   = 3'd3,
    ST_HRD  = 3'd4,
    ST_HWR  = 3'd5
  } state_t;

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------

  // Membrane update: add at MEM_W+1 bits, then either clamp or wrap to MEM_W.
  function automatic logic [MEM_W-1:0] mem_add(
    input logic [MEM_W-1:0] mem,
    input logic [MEM_W-1:0] delta
  );
    logic [MEM_W:0] wide;
    wide = {mem[MEM_W-1], mem} + {delta[MEM_W-1], delta};
`ifdef PNS_MEM_SAT_EN
    // The two top bits disagree only when the true sum left the MEM_W range;
    // the extra sign bit tells which side it overflowed to.
    if (wide[MEM_W] != wide[MEM_W-1]) begin
      if (wide[MEM_W]) begin
        mem_add = {1'b1, {(MEM_W-1){1'b0}}};
      end else begin
        mem_add = {1'b0, {(MEM_W-1){1'b1}}};
      end
    end else begin
      mem_add = wide[MEM_W-1:0];
    end
`else
    mem_add = wide[MEM_W-1:0];
`endif
  endfunction

  // Spike counter increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] cnt);
    if (cnt == {CNT_W{1'b1}}) begin
      cnt_inc = cnt;
    end else begin
      cnt_inc = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // -------------------------------------------------------------------------
  // State and registers
  // -------------------------------------------------------------------------
  state_t                  state_r;
  state_t                  next_state_s;
  logic                    rr_last_r;

  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [MEM_W-1:0]        delta_r;
  logic [DATA_WIDTH-1:0]   sram_d_r;
  logic                    sram_cs_r;
  logic                    sram_we_r;
  logic                    spike_valid_r;
  logic [ADDR_WIDTH-1:0]   spike_addr_r;
  logic                    host_rvalid_r;
  logic [DATA_WIDTH-1:0]   rdata_hold_r;
  logic                    busy_r;

  logic                    grant_int_s;
  logic                    grant_host_s;
  logic                    cs_next_s;
  logic                    we_next_s;

  logic [MEM_W-1:0]        sum_s;
  logic                    fire_s;
  logic [DATA_WIDTH-1:0]   calc_word_s;

  // Round-robin arbitration, only meaningful in IDLE.
  always_comb begin
    grant_int_s  = 1'b0;
    grant_host_s = 1'b0;
    if (state_r == ST_IDLE) begin
      // A lone requester always wins; on contention the one that was not
      // served last wins.
      grant_int_s  = int_req  && (!host_req || (rr_last_r == RR_HOST));
      grant_host_s = host_req && (!int_req  || (rr_last_r == RR_INT));
    end else begin
      grant_int_s  = 1'b0;
      grant_host_s = 1'b0;
    end
  end

  // Next-state decode plus the SRAM strobes the next state will need.
  always_comb begin
    next_state_s = state_r;
    cs_next_s    = 1'b0;
    we_next_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (grant_int_s) begin
          next_state_s = ST_RD;
        end else if (grant_host_s) begin
          if (host_we) begin
            next_state_s = ST_HWR;
          end else begin
            next_state_s = ST_HRD;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_RD:   next_state_s = ST_CALC;
      ST_CALC: next_state_s = ST_WB;
      ST_WB:   next_state_s = ST_IDLE;
      ST_HRD:  next_state_s = ST_IDLE;
      ST_HWR:  next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase

    // SRAM strobes are registered, so they are decoded from the state the
    // sequencer is about to enter.
    case (next_state_s)
      ST_RD:   begin cs_next_s = 1'b1; we_next_s = 1'b0; end
      ST_WB:   begin cs_next_s = 1'b1; we_next_s = 1'b1; end
      ST_HRD:  begin cs_next_s = 1'b1; we_next_s = 1'b0; end
      ST_HWR:  begin cs_next_s = 1'b1; we_next_s = 1'b1; end
      ST_IDLE: begin cs_next_s = 1'b0; we_next_s = 1'b0; end
      ST_CALC: begin cs_next_s = 1'b0; we_next_s = 1'b0; end
      default: begin cs_next_s = 1'b0; we_next_s = 1'b0; end
    endcase
  end

  // Read-modify-write arithmetic on the word returned by the RD access.
  always_comb begin
    sum_s       = mem_add(sram_q[MEM_W-1:0], delta_r);
    fire_s      = ($signed(sum_s) >= THRESHOLD);
    calc_word_s = {sram_q[DATA_WIDTH-1:MEM_W], sum_s};
    if (fire_s) begin
      calc_word_s = {cnt_inc(sram_q[DATA_WIDTH-1:MEM_W]), {MEM_W{1'b0}}};
    end else begin
      calc_word_s = {sram_q[DATA_WIDTH-1:MEM_W], sum_s};
    end
  end

  // Control registers: FSM state, arbitration history and output strobes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r       <= ST_IDLE;
      rr_last_r     <= RR_HOST;
      sram_cs_r     <= 1'b0;
      sram_we_r     <= 1'b0;
      spike_valid_r <= 1'b0;
      host_rvalid_r <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= next_state_s;
      sram_cs_r     <= cs_next_s;
      sram_we_r     <= we_next_s;
      busy_r        <= (next_state_s != ST_IDLE);
      // Spike strobe lines up with the WB cycle that follows CALC.
      spike_valid_r <= (state_r == ST_CALC) && fire_s;
      // Read data arrives the cycle after HRD, which is always IDLE.
      host_rvalid_r <= (state_r == ST_HRD);
      if (grant_int_s) begin
        rr_last_r <= RR_INT;
      end else if (grant_host_s) begin
        rr_last_r <= RR_HOST;
      end
    end
  end

  // Datapath registers: latched request fields, write data and read hold.
  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_r       <= {ADDR_WIDTH{1'b0}};
      delta_r      <= {MEM_W{1'b0}};
      sram_d_r     <= {DATA_WIDTH{1'b0}};
      spike_addr_r <= {ADDR_WIDTH{1'b0}};
      rdata_hold_r <= {DATA_WIDTH{1'b0}};
    end else begin
      if (grant_int_s) begin
        addr_r  <= int_addr;
        delta_r <= int_delta;
      end else if (grant_host_s) begin
        addr_r <= host_addr;
        if (host_we) begin
          sram_d_r <= host_wdata;
        end
      end
      // sram_d doubles as the registered RMW result presented during WB.
      if (state_r == ST_CALC) begin
        sram_d_r <= calc_word_s;
        if (fire_s) begin
          spike_addr_r <= addr_r;
        end
      end
      // Keep the last read word visible after the strobe drops.
      if (host_rvalid_r) begin
        rdata_hold_r <= sram_q;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign int_ack     = grant_int_s;
  assign host_ack    = grant_host_s;
  assign sram_cs     = sram_cs_r;
  assign sram_we     = sram_we_r;
  assign sram_a      = addr_r;
  assign sram_d      = sram_d_r;
  assign spike_valid = spike_valid_r;
  assign spike_addr  = spike_addr_r;
  assign host_rvalid = host_rvalid_r;
  // sram_q is only valid during the strobe cycle, so it is forwarded then.
  assign host_rdata  = host_rvalid_r ? sram_q : rdata_hold_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_post_neuron_sram_ctrl.sv
// Directed testbench for post_neuron_sram_ctrl with a behavioural SRAM.
module tb_post_neuron_sram_ctrl;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int MW = 16;

  logic          CLK = 1'b0;
  logic          RST;
  logic          int_req;
  logic [AW-1:0] int_addr;
  logic [MW-1:0] int_delta;
  logic          int_ack;
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_ack;
  logic [DW-1:0] host_rdata;
  logic          host_rvalid;
  logic          spike_valid;
  logic [AW-1:0] spike_addr;
  logic          sram_cs;
  logic          sram_we;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_d;
  logic [DW-1:0] sram_q = 32'h0000_0000;
  logic          busy;

  int vectors     = 0;
  int miscompares = 0;
  int we_count    = 0;
  int spike_count = 0;

  logic [DW-1:0] mem_model [0:255];

  always #5 CLK = ~CLK;

  post_neuron_sram_ctrl dut (
    .CLK(CLK), .RST(RST),
    .int_req(int_req), .int_addr(int_addr), .int_delta(int_delta), .int_ack(int_ack),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .spike_valid(spike_valid), .spike_addr(spike_addr),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_a(sram_a), .sram_d(sram_d),
    .sram_q(sram_q), .busy(busy)
  );

  // Single-port SRAM with a one-cycle registered read, plus event counters.
  always @(posedge CLK) begin
    if (sram_cs) begin
      if (sram_we) begin
        mem_model[sram_a] <= sram_d;
        we_count <= we_count + 1;
      end else begin
        sram_q <= mem_model[sram_a];
      end
    end
    if (spike_valid) spike_count <= spike_count + 1;
  end

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_host_write(input logic [AW-1:0] a, input logic [DW-1:0] dat, output int waits);
    waits = 0;
    next_cycle();
    host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = dat;
    #1;
    while (host_ack !== 1'b1 && waits < 10) begin next_cycle(); #1; waits++; end
    next_cycle();
    host_req = 1'b0; host_we = 1'b0;
  endtask

  task automatic do_host_read(input logic [AW-1:0] a, output int waits, output logic rv, output logic [DW-1:0] rd);
    waits = 0;
    next_cycle();
    host_req = 1'b1; host_we = 1'b0; host_addr = a;
    #1;
    while (host_ack !== 1'b1 && waits < 10) begin next_cycle(); #1; waits++; end
    next_cycle();
    host_req = 1'b0;
    next_cycle();
    #1;
    rv = host_rvalid; rd = host_rdata;
  endtask

  // Runs one integration; samples the SRAM pins and spike outputs at ack+3.
  task automatic do_int(input logic [AW-1:0] a, input logic [MW-1:0] d, output int waits,
                        output logic wb_seen, output logic [DW-1:0] wb_word,
                        output logic spk, output logic [AW-1:0] spk_a);
    waits = 0; wb_seen = 1'b0; wb_word = 32'h0000_0000; spk = 1'b0; spk_a = 8'h00;
    next_cycle();
    int_req = 1'b1; int_addr = a; int_delta = d;
    #1;
    while (int_ack !== 1'b1 && waits < 10) begin next_cycle(); #1; waits++; end
    if (int_ack !== 1'b1) begin int_req = 1'b0; return; end
    next_cycle();
    int_req = 1'b0;
    next_cycle();
    next_cycle();
    #1;
    wb_seen = sram_cs && sram_we; wb_word = sram_d; spk = spike_valid; spk_a = spike_addr;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    int_req = 1'b0; int_addr = 8'h00; int_delta = 16'h0000;
    host_req = 1'b0; host_we = 1'b0; host_addr = 8'h00; host_wdata = 32'h0000_0000;
    next_cycle(); next_cycle(); #1;
    vectors++;
    if ({int_ack, host_ack, host_rvalid, spike_valid, sram_cs, sram_we} !== 6'b000000) begin
      miscompares++;
      $display("FAIL reset_strobes: got %b expected 000000", {int_ack, host_ack, host_rvalid, spike_valid, sram_cs, sram_we});
    end
    vectors++;
    if ({host_rdata, spike_addr, busy} !== {32'h0000_0000, 8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_data: got rdata=%h spike_addr=%h busy=%b expected 0/0/0", host_rdata, spike_addr, busy);
    end
    next_cycle();
    RST = 1'b0;
  endtask

  task automatic test_host_write_read();
    next_cycle();
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h05; host_wdata = 32'h0000_0100;
    #1;
    vectors++;
    if (host_ack !== 1'b1) begin miscompares++; $display("FAIL hwr_ack: got %b expected 1", host_ack); end
    next_cycle();
    host_req = 1'b0; host_we = 1'b0;
    #1;
    vectors++;
    if ({sram_cs, sram_we, sram_a, sram_d, busy} !== {1'b1, 1'b1, 8'h05, 32'h0000_0100, 1'b1}) begin
      miscompares++;
      $display("FAIL hwr_pins: got cs=%b we=%b a=%h d=%h busy=%b expected 1 1 05 00000100 1", sram_cs, sram_we, sram_a, sram_d, busy);
    end
    next_cycle();
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h05;
    #1;
    vectors++;
    if (host_ack !== 1'b1) begin miscompares++; $display("FAIL hrd_ack: got %b expected 1", host_ack); end
    next_cycle();
    host_req = 1'b0;
    #1;
    vectors++;
    if ({host_rvalid, sram_cs, sram_we} !== 3'b010) begin
      miscompares++;
      $display("FAIL hrd_cycle: got rvalid/cs/we=%b expected 010", {host_rvalid, sram_cs, sram_we});
    end
    next_cycle(); #1;
    vectors++;
    if ({host_rvalid, host_rdata} !== {1'b1, 32'h0000_0100}) begin
      miscompares++;
      $display("FAIL hrd_data: got rvalid=%b rdata=%h expected 1 00000100", host_rvalid, host_rdata);
    end
    next_cycle(); #1;
    vectors++;
    if ({host_rvalid, host_rdata} !== {1'b0, 32'h0000_0100}) begin
      miscompares++;
      $display("FAIL hrd_hold: got rvalid=%b rdata=%h expected 0 00000100", host_rvalid, host_rdata);
    end
  endtask

  task automatic test_integrate();
    int w; logic wb; logic [DW-1:0] word; logic spk; logic [AW-1:0] sa;
    do_int(8'h05, 16'h0200, w, wb, word, spk, sa);
    vectors++;
    if ({w == 0, wb, word, spk} !== {1'b1, 1'b1, 32'h0000_0300, 1'b0}) begin
      miscompares++;
      $display("FAIL int_nofire: got waits=%0d wb=%b word=%h spike=%b expected 0 1 00000300 0", w, wb, word, spk);
    end
    do_int(8'h05, 16'h0100, w, wb, word, spk, sa);
    vectors++;
    if ({w == 0, wb, word, spk, sa} !== {1'b1, 1'b1, 32'h0001_0000, 1'b1, 8'h05}) begin
      miscompares++;
      $display("FAIL int_fire: got waits=%0d wb=%b word=%h spike=%b addr=%h expected 0 1 00010000 1 05", w, wb, word, spk, sa);
    end
  endtask

  task automatic test_arbitration();
    int w;
    do_host_write(8'h09, 32'h0000_0000, w);
    next_cycle(); RST = 1'b1;
    next_cycle(); RST = 1'b0;
    next_cycle();
    int_req = 1'b1; int_addr = 8'h09; int_delta = 16'h0001;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h09;
    #1;
    vectors++;
    if ({int_ack, host_ack} !== 2'b10) begin
      miscompares++;
      $display("FAIL arb_first: got int_ack/host_ack=%b expected 10", {int_ack, host_ack});
    end
    next_cycle();
    int_req = 1'b0;
    #1;
    vectors++;
    if (host_ack !== 1'b0) begin miscompares++; $display("FAIL arb_busy: got host_ack=%b expected 0", host_ack); end
    next_cycle(); next_cycle(); next_cycle(); #1;
    vectors++;
    if (host_ack !== 1'b1) begin miscompares++; $display("FAIL arb_second: got host_ack=%b expected 1", host_ack); end
    next_cycle();
    host_req = 1'b0;
    next_cycle(); #1;
    vectors++;
    if ({host_rvalid, host_rdata} !== {1'b1, 32'h0000_0001}) begin
      miscompares++;
      $display("FAIL arb_readback: got rvalid=%b rdata=%h expected 1 00000001", host_rvalid, host_rdata);
    end
    // Host was served last, so integration wins the next contention.
    next_cycle();
    int_req = 1'b1; int_addr = 8'h09; int_delta = 16'h0000;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h09;
    #1;
    vectors++;
    if ({int_ack, host_ack} !== 2'b10) begin
      miscompares++;
      $display("FAIL arb_rr: got int_ack/host_ack=%b expected 10", {int_ack, host_ack});
    end
    next_cycle();
    int_req = 1'b0; host_req = 1'b0;
    next_cycle(); next_cycle(); next_cycle(); #1;
    vectors++;
    if ({host_ack, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL arb_dropped: got host_ack/busy=%b expected 00", {host_ack, busy});
    end
  endtask

  task automatic test_back_to_back();
    int w; logic wb; logic [DW-1:0] word; logic spk; logic [AW-1:0] sa;
    do_int(8'h09, 16'h0002, w, wb, word, spk, sa);
    vectors++;
    if ({w == 0, word} !== {1'b1, 32'h0000_0003}) begin
      miscompares++;
      $display("FAIL b2b_first: got waits=%0d word=%h expected 0 00000003", w, word);
    end
    do_int(8'h09, 16'h0003, w, wb, word, spk, sa);
    vectors++;
    if ({w == 0, wb, word} !== {1'b1, 1'b1, 32'h0000_0006}) begin
      miscompares++;
      $display("FAIL b2b_second: got waits=%0d wb=%b word=%h expected 0 1 00000006", w, wb, word);
    end
  endtask

  task automatic test_threshold_edge();
    int w; logic wb; logic [DW-1:0] word; logic spk; logic [AW-1:0] sa;
    do_host_write(8'h41, 32'h0000_03FE, w);
    do_int(8'h41, 16'h0001, w, wb, word, spk, sa);
    vectors++;
    if ({word, spk} !== {32'h0000_03FF, 1'b0}) begin
      miscompares++;
      $display("FAIL thr_below: got word=%h spike=%b expected 000003ff 0", word, spk);
    end
    do_int(8'h41, 16'hFC00, w, wb, word, spk, sa);
    vectors++;
    if ({word, spk} !== {32'h0000_FFFF, 1'b0}) begin
      miscompares++;
      $display("FAIL thr_negative: got word=%h spike=%b expected 0000ffff 0", word, spk);
    end
  endtask

  task automatic test_overflow();
    int w; logic wb; logic [DW-1:0] word; logic spk; logic [AW-1:0] sa;
    logic [DW-1:0] exp_word; logic exp_spk;
`ifdef PNS_MEM_SAT_EN
    exp_word = 32'h0001_0000; exp_spk = 1'b1;
`else
    exp_word = 32'h0000_8010; exp_spk = 1'b0;
`endif
    do_host_write(8'h20, 32'h0000_7FF0, w);
    do_int(8'h20, 16'h0020, w, wb, word, spk, sa);
    vectors++;
    if ({word, spk} !== {exp_word, exp_spk}) begin
      miscompares++;
      $display("FAIL overflow: got word=%h spike=%b expected %h %b", word, spk, exp_word, exp_spk);
    end
  endtask

  task automatic test_cnt_saturate();
    int w; logic wb; logic [DW-1:0] word; logic spk; logic [AW-1:0] sa;
    do_host_write(8'h40, 32'hFFFF_03FF, w);
    do_int(8'h40, 16'h0001, w, wb, word, spk, sa);
    vectors++;
    if ({word, spk, sa} !== {32'hFFFF_0000, 1'b1, 8'h40}) begin
      miscompares++;
      $display("FAIL cnt_sat: got word=%h spike=%b addr=%h expected ffff0000 1 40", word, spk, sa);
    end
  endtask

  task automatic test_reset_mid_op();
    int w; int we0; int sp0; logic rv; logic [DW-1:0] rd;
    do_host_write(8'h30, 32'h0000_0050, w);
    next_cycle();
    we0 = we_count; sp0 = spike_count;
    int_req = 1'b1; int_addr = 8'h30; int_delta = 16'h0500;
    #1;
    vectors++;
    if (int_ack !== 1'b1) begin miscompares++; $display("FAIL rst_ack: got %b expected 1", int_ack); end
    next_cycle();
    int_req = 1'b0;
    next_cycle();
    RST = 1'b1;
    #1;
    vectors++;
    if (sram_cs !== 1'b0) begin miscompares++; $display("FAIL calc_cs: got %b expected 0", sram_cs); end
    next_cycle();
    RST = 1'b0;
    #1;
    vectors++;
    if ({busy, sram_we, spike_valid} !== 3'b000) begin
      miscompares++;
      $display("FAIL rst_abort: got busy/we/spike=%b expected 000", {busy, sram_we, spike_valid});
    end
    next_cycle(); next_cycle();
    vectors++;
    if ({we_count - we0, spike_count - sp0} !== {32'd0, 32'd0}) begin
      miscompares++;
      $display("FAIL rst_events: got writes=%0d spikes=%0d expected 0 0", we_count - we0, spike_count - sp0);
    end
    do_host_read(8'h30, w, rv, rd);
    vectors++;
    if ({rv, rd} !== {1'b1, 32'h0000_0050}) begin
      miscompares++;
      $display("FAIL rst_readback: got rvalid=%b rdata=%h expected 1 00000050", rv, rd);
    end
  endtask

  initial begin
    test_reset();
    test_host_write_read();
    test_integrate();
    test_arbitration();
    test_back_to_back();
    test_threshold_edge();
    test_overflow();
    test_cnt_saturate();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
